conv_layer_scheduler: RTL and testbench

Sequences one convolution layer across the PE array controller: iterates every (kernel, input channel) pass, fetches the weights for each pass, launches the PE controller with `start_conv` for the first pass and `start_again` for later passes, and waits for its `end_conv`. It also drives partial-sum clear/accumulate and output-feature-map write strobes for the psum buffer. A watchdog flags a hung pass. It sits between the top-level layer sequencer and the PE controller.

---
 rtl/conv_layer_scheduler_pkg.sv | 21 ++
 rtl/conv_layer_scheduler_watchdog.sv | 28 ++
 rtl/conv_layer_scheduler.sv | 159 +++++++++++++++
 tb/tb_conv_layer_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_scheduler_pkg.sv
// Shared types for the convolution layer scheduler:
// FSM state encoding and index width.
package conv_layer_scheduler_pkg;

    localparam int IDX_W = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_WGT_REQ = 3'b001,
        S_START   = 3'b010,
        S_RUN     = 3'b011,
        S_ADVANCE = 3'b100,
        S_DONE    = 3'b101,
        S_ERROR   = 3'b110
    } state_t;

    function automatic logic is_busy(input state_t s);
        return !(s inside {S_IDLE, S_DONE, S_ERROR});
    endfunction

endpackage

// File: rtl/conv_layer_scheduler_watchdog.sv
// Pass watchdog: cleared by load, counts while enabled,
// saturates and flags expiry at LIMIT-1.
module pass_watchdog #(
    parameter int LIMIT = 16,
    parameter int W     = $clog2(LIMIT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    logic [W-1:0] count_q;

    assign expire_o = (count_q == W'(LIMIT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= '0;
        end else if (en_i && !expire_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Walks every (kernel, channel) pass of one layer, fetching
// weights and launching the PE controller for each pass.
module conv_layer_scheduler
    import conv_layer_scheduler_pkg::*;
#(
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int IFM_WIDTH   = 64,
    parameter int IFM_HEIGHT  = 64,
    parameter int KERNEL_SIZE = 3,
    parameter int TIMEOUT     = IFM_WIDTH * IFM_HEIGHT + KERNEL_SIZE + 16,
    parameter int WGT_AW      = 8
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              layer_start,
    input  logic              err_clear,
    output logic              wgt_req,
    output logic [WGT_AW-1:0] wgt_addr,
    input  logic              wgt_ack,
    output logic              pe_start_conv,
    output logic              pe_start_again,
    input  logic              pe_end_conv,
    output logic [IDX_W-1:0]  kernel_idx,
    output logic [IDX_W-1:0]  channel_idx,
    output logic              psum_clear,
    output logic              psum_accum,
    output logic              ofm_write,
    output logic              layer_busy,
    output logic              layer_done,
    output logic              error
);

    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CHANNEL - 1);
    localparam logic [IDX_W-1:0] LAST_K  = IDX_W'(NUM_KERNEL - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   kern_q, kern_d;
    logic [IDX_W-1:0]   chan_q, chan_d;
    logic               first_q, first_d;
    logic [WGT_AW-1:0]  addr_q, addr_d;
    logic               req_q, sconv_q, sagain_q;
    logic               clr_q, acc_q, ofm_q;
    logic               busy_q, done_q, err_q;
    logic               wd_expire;

    pass_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_wd (
        .clk_i    (clk1),
        .rst_i    (rst),
        .load_i   (state_q == S_START),
        .en_i     (state_q == S_RUN),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        kern_d  = kern_q;
        chan_d  = chan_q;
        first_d = first_q;
        unique case (state_q)
            S_IDLE: begin
                if (layer_start) begin
                    state_d = S_WGT_REQ;
                    kern_d  = '0;
                    chan_d  = '0;
                    first_d = 1'b1;
                end
            end
            S_WGT_REQ: begin
                if (wgt_ack) state_d = S_START;
            end
            S_START: begin
                first_d = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // A finishing pass beats a same-cycle expiry.
                if (pe_end_conv)    state_d = S_ADVANCE;
                else if (wd_expire) state_d = S_ERROR;
            end
            S_ADVANCE: begin
                if (chan_q < LAST_CH) begin
                    chan_d  = chan_q + 1'b1;
                    state_d = S_WGT_REQ;
                end else begin
                    chan_d = '0;
                    if (kern_q == LAST_K) begin
                        state_d = S_DONE;
                    end else begin
                        kern_d  = kern_q + 1'b1;
                        state_d = S_WGT_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (err_clear) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign addr_d = WGT_AW'(32'(kern_d) * 32'(NUM_CHANNEL) + 32'(chan_d));

    // Outputs are decoded from next state so they align with it.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q  <= S_IDLE;
            kern_q   <= '0;
            chan_q   <= '0;
            first_q  <= 1'b0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            sconv_q  <= 1'b0;
            sagain_q <= 1'b0;
            clr_q    <= 1'b0;
            acc_q    <= 1'b0;
            ofm_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kern_q   <= kern_d;
            chan_q   <= chan_d;
            first_q  <= first_d;
            addr_q   <= addr_d;
            req_q    <= (state_d == S_WGT_REQ);
            sconv_q  <= (state_d == S_START) && first_q;
            sagain_q <= (state_d == S_START) && !first_q;
            clr_q    <= (state_d == S_RUN) && (chan_d == '0);
            acc_q    <= (state_d == S_RUN) && (chan_d != '0);
            ofm_q    <= (state_d == S_ADVANCE) && (chan_d == LAST_CH);
            busy_q   <= is_busy(state_d);
            done_q   <= (state_d == S_DONE);
            err_q    <= (state_d == S_ERROR);
        end
    end

    assign wgt_req        = req_q;
    assign wgt_addr       = addr_q;
    assign pe_start_conv  = sconv_q;
    assign pe_start_again = sagain_q;
    assign kernel_idx     = kern_q;
    assign channel_idx    = chan_q;
    assign psum_clear     = clr_q;
    assign psum_accum     = acc_q;
    assign ofm_write      = ofm_q;
    assign layer_busy     = busy_q;
    assign layer_done     = done_q;
    assign error          = err_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler (3 channels, 2 kernels).
module tb_conv_layer_scheduler;

    localparam int TO = 64 * 64 + 3 + 16;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       layer_start = 1'b0;
    logic       err_clear = 1'b0;
    logic       wgt_ack = 1'b0;
    logic       pe_end_conv = 1'b0;
    logic       wgt_req;
    logic [7:0] wgt_addr;
    logic       pe_start_conv;
    logic       pe_start_again;
    logic [4:0] kernel_idx;
    logic [4:0] channel_idx;
    logic       psum_clear;
    logic       psum_accum;
    logic       ofm_write;
    logic       layer_busy;
    logic       layer_done;
    logic       error;

    int n_chk = 0;
    int n_bad = 0;
    int c_conv = 0, c_again = 0, c_ofm = 0, c_done = 0;
    int b_conv, b_again, b_ofm, b_done;

    conv_layer_scheduler #(
        .NUM_CHANNEL (3),
        .NUM_KERNEL  (2)
    ) dut (
        .clk1           (clk1),
        .rst            (rst),
        .layer_start    (layer_start),
        .err_clear      (err_clear),
        .wgt_req        (wgt_req),
        .wgt_addr       (wgt_addr),
        .wgt_ack        (wgt_ack),
        .pe_start_conv  (pe_start_conv),
        .pe_start_again (pe_start_again),
        .pe_end_conv    (pe_end_conv),
        .kernel_idx     (kernel_idx),
        .channel_idx    (channel_idx),
        .psum_clear     (psum_clear),
        .psum_accum     (psum_accum),
        .ofm_write      (ofm_write),
        .layer_busy     (layer_busy),
        .layer_done     (layer_done),
        .error          (error)
    );

    always #5 clk1 = ~clk1;

    always @(negedge clk1) begin
        if (pe_start_conv)  c_conv  <= c_conv + 1;
        if (pe_start_again) c_again <= c_again + 1;
        if (ofm_write)      c_ofm   <= c_ofm + 1;
        if (layer_done)     c_done  <= c_done + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk1);
    endtask

    // Entry: negedge of the first wgt_req cycle of pass p.
    // Exit: negedge of the first RUN cycle.
    task automatic pass_to_run(input int p);
        chk("req", wgt_req, 1);
        chk("addr", wgt_addr, p);
        chk("kidx", kernel_idx, p / 3);
        chk("cidx", channel_idx, p % 3);
        step();
        chk("addr_hold", wgt_addr, p);
        step();
        wgt_ack = 1'b1;
        step();
        wgt_ack = 1'b0;
        chk("sconv", pe_start_conv, int'(p == 0));
        chk("sagain", pe_start_again, int'(p != 0));
        chk("req_off", wgt_req, 0);
        step();
        chk("clr", psum_clear, int'((p % 3) == 0));
        chk("acc", psum_accum, int'((p % 3) != 0));
    endtask

    task automatic pass_finish(input int p, input bit last, input int n);
        repeat (n) step();
        chk("clr_end", psum_clear, int'((p % 3) == 0));
        chk("acc_end", psum_accum, int'((p % 3) != 0));
        pe_end_conv = 1'b1;
        step();
        pe_end_conv = 1'b0;
        chk("ofm", ofm_write, int'((p % 3) == 2));
        chk("adv_busy", layer_busy, 1);
        chk("adv_clr", psum_clear, 0);
        step();
        if (last) begin
            chk("done", layer_done, 1);
            chk("done_busy", layer_busy, 0);
        end else begin
            chk("next_req", wgt_req, 1);
        end
    endtask

    task automatic launch();
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_req", wgt_req, 0);
        chk("rst_addr", wgt_addr, 0);
        chk("rst_busy", layer_busy, 0);
        chk("rst_err", error, 0);
        chk("rst_kidx", kernel_idx, 0);

        // spurious handshakes in IDLE
        pe_end_conv = 1'b1;
        wgt_ack     = 1'b1;
        step();
        pe_end_conv = 1'b0;
        wgt_ack     = 1'b0;
        step();
        chk("spur_busy", layer_busy, 0);
        chk("spur_req", wgt_req, 0);
        chk("spur_start", pe_start_conv, 0);

        // full layer: 6 passes
        b_conv  = c_conv;
        b_again = c_again;
        b_ofm   = c_ofm;
        b_done  = c_done;
        launch();
        for (int p = 0; p < 6; p++) begin
            pass_to_run(p);
            if (p == 0) begin
                launch();
                chk("restart_busy", layer_busy, 1);
                chk("restart_req", wgt_req, 0);
                pass_finish(p, 1'b0, 8);
            end else begin
                pass_finish(p, p == 5, 9);
            end
        end
        step();
        chk("done_pulse", layer_done, 0);
        chk("final_kidx", kernel_idx, 1);
        chk("final_cidx", channel_idx, 0);
        chk("n_conv", c_conv - b_conv, 1);
        chk("n_again", c_again - b_again, 5);
        chk("n_ofm", c_ofm - b_ofm, 2);
        chk("n_done", c_done - b_done, 1);

        // timeout
        launch();
        pass_to_run(0);
        repeat (TO - 1) step();
        chk("to_early", error, 0);
        step();
        chk("to_err", error, 1);
        chk("to_busy", layer_busy, 0);
        launch();
        step();
        chk("to_sticky", error, 1);
        chk("to_noreq", wgt_req, 0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("clr_err", error, 0);
        chk("clr_busy", layer_busy, 0);

        // end_conv coinciding with expiry
        launch();
        pass_to_run(0);
        repeat (TO - 1) step();
        pe_end_conv = 1'b1;
        step();
        pe_end_conv = 1'b0;
        chk("tie_err", error, 0);
        chk("tie_busy", layer_busy, 1);
        step();
        chk("tie_err2", error, 0);
        pass_to_run(1);
        pass_finish(1, 1'b0, 9);

        // reset in WGT_REQ of pass 2
        chk("pre_rst_addr", wgt_addr, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_req", wgt_req, 0);
        chk("mr_addr", wgt_addr, 0);
        chk("mr_cidx", channel_idx, 0);
        chk("mr_busy", layer_busy, 0);
        chk("mr_start", pe_start_again, 0);
        launch();
        pass_to_run(0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
